// File: rtl/mux_channel_scanner.sv
// mux_channel_scanner
//   Upstream sequencer for a 4:1 data selector. Steps o_Sel through the
//   channels, holding each one for DWELL cycles. It samples the selector
//   output at dwell index SETTLE into one capture register per channel.
//   o_Valid pulses for one cycle when a full frame has been captured.
//   Runs either single-shot or back-to-back (i_Continuous).
//
//   Optional feature macro: MUX_SCAN_MASK_EN
//     Adds i_Mask[3:0], where 1 means the channel is enabled. Disabled
//     channels are skipped entirely.
//
// Ports
//   i_Clk         rising-edge clock
//   i_Reset       synchronous, active-high reset
//   i_Start       start request (ignored while scanning)
//   i_Continuous  1 = restart frames back to back, sampled at frame end
//   i_Mask        channel enable mask (MUX_SCAN_MASK_EN only)
//   i_Dato        selector output
//   o_Sel         select driven to the selector
//   o_Dato_0..3   captured value per channel
//   o_Valid       1-cycle pulse, frame complete
//   o_Busy        scan in progress
//
// state | meaning
// IDLE  | waiting for i_Start, o_Sel parked at 0
// SCAN  | dwelling on channel o_Sel, cnt = cycle index within dwell

module mux_channel_scanner #(
    parameter int DATA_W = 4,
    parameter int DWELL  = 5,
    parameter int SETTLE = 1
) (
    input  logic              i_Clk,
    input  logic              i_Reset,
    input  logic              i_Start,
    input  logic              i_Continuous,
`ifdef MUX_SCAN_MASK_EN
    input  logic [3:0]        i_Mask,
`endif
    input  logic [DATA_W-1:0] i_Dato,
    output logic [1:0]        o_Sel,
    output logic [DATA_W-1:0] o_Dato_0,
    output logic [DATA_W-1:0] o_Dato_1,
    output logic [DATA_W-1:0] o_Dato_2,
    output logic [DATA_W-1:0] o_Dato_3,
    output logic              o_Valid,
    output logic              o_Busy
);

    localparam int              CNT_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic [DATA_W-1:0]  dato_q [4];
    logic [DATA_W-1:0]  dato_d [4];

    // start_mask: mask that a new frame would use; scan_mask: mask of the
    // frame in progress. Without the mask feature both are all-ones.
    logic [3:0] start_mask;
    logic [3:0] scan_mask;

`ifdef MUX_SCAN_MASK_EN
    logic [3:0] mask_q, mask_d;
    assign start_mask = i_Mask;
    assign scan_mask  = mask_q;
`else
    assign start_mask = 4'hF;
    assign scan_mask  = 4'hF;
`endif

    function automatic logic [1:0] first_ch(input logic [3:0] m);
        first_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) first_ch = 2'(i);
        end
    endfunction

    function automatic logic [1:0] last_ch(input logic [3:0] m);
        last_ch = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (m[i]) last_ch = 2'(i);
        end
    endfunction

    function automatic logic [1:0] next_ch(input logic [3:0] m, input logic [1:0] cur);
        logic found;
        found   = 1'b0;
        next_ch = cur;
        for (int i = 0; i < 4; i++) begin
            if (!found && (i > int'(cur)) && m[i]) begin
                next_ch = 2'(i);
                found   = 1'b1;
            end
        end
    endfunction

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        dato_d  = dato_q;
`ifdef MUX_SCAN_MASK_EN
        mask_d  = mask_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_Start && (start_mask != 4'd0)) begin
                    state_d = SCAN;
                    sel_d   = first_ch(start_mask);
                    cnt_d   = '0;
`ifdef MUX_SCAN_MASK_EN
                    mask_d  = start_mask;
`endif
                end
            end
            SCAN: begin
                // Selector is combinational, so i_Dato already reflects sel_q.
                if (cnt_q == CNT_SETTLE) dato_d[sel_q] = i_Dato;
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (sel_q != last_ch(scan_mask)) begin
                        sel_d = next_ch(scan_mask, sel_q);
                    end else if (i_Continuous && (start_mask != 4'd0)) begin
                        valid_d = 1'b1;
                        sel_d   = first_ch(start_mask);
`ifdef MUX_SCAN_MASK_EN
                        mask_d  = start_mask;
`endif
                    end else if (i_Continuous) begin
                        // Restart with an empty mask: abandon quietly.
                        state_d = IDLE;
                        sel_d   = 2'd0;
                    end else begin
                        valid_d = 1'b1;
                        state_d = IDLE;
                        sel_d   = 2'd0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            dato_q  <= '{default: '0};
`ifdef MUX_SCAN_MASK_EN
            mask_q  <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            dato_q  <= dato_d;
`ifdef MUX_SCAN_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign o_Sel    = sel_q;
    assign o_Valid  = valid_q;
    assign o_Busy   = (state_q == SCAN);
    assign o_Dato_0 = dato_q[0];
    assign o_Dato_1 = dato_q[1];
    assign o_Dato_2 = dato_q[2];
    assign o_Dato_3 = dato_q[3];

endmodule
